sram_like_arbiter: RTL

//   Parametrised N-channel arbiter for the CPU's sram-like memory interface (req/addr_ok/data_ok).

---
 rtl/sram_like_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Merges NCH upstream sram-like channels (req/addr_ok/data_ok) onto one
//   downstream sram-like port. Up to DEPTH transactions may be outstanding;
//   a small ID FIFO remembers which channel issued each one so in-order
//   responses can be routed back. A per-channel cancel drops responses
//   still owed to a channel, e.g. after a pipeline flush.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   ch_req/ch_wr      per-channel request / write flag           [NCH]
//   ch_size           per-channel size, bytes-1                  [2*NCH]
//   ch_addr/ch_wdata  per-channel address / write data           [AW*NCH]/[DW*NCH]
//   ch_cancel         drop outstanding responses owed to channel [NCH]
//   ch_addr_ok        request accepted                           [NCH]
//   ch_data_ok        response valid for channel                 [NCH]
//   ch_rdata          read data, broadcast to all channels       [DW]
//   m_*               downstream sram-like master port
//   busy              transactions outstanding
//   proto_err         sticky: downstream response with nothing outstanding

// Per-channel response gate: one instance per channel.
module sram_like_arbiter_rsp #(
  parameter int IW = 1,
  parameter int CH = 0
) (
  input  logic          pop,
  input  logic [IW-1:0] head_id,
  input  logic          head_cx,
  input  logic          cancel,
  output logic          data_ok
);
  // A cancel arriving in the pop cycle still suppresses delivery.
  assign data_ok = pop & (head_id == IW'(CH)) & ~head_cx & ~cancel;
endmodule

module sram_like_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter bit RR    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [2*NCH-1:0]  ch_size,
  input  logic [AW*NCH-1:0] ch_addr,
  input  logic [DW*NCH-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_cancel,
  output logic [NCH-1:0]    ch_addr_ok,
  output logic [NCH-1:0]    ch_data_ok,
  output logic [DW-1:0]     ch_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DW-1:0]     m_rdata,
  output logic              busy,
  output logic              proto_err
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [IW-1:0] id;
    logic          cx;   // response owed to a flushed request
  } ent_t;

  ent_t [DEPTH-1:0] fifo_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             lock_q;
  logic [NCH-1:0]   lock_gnt_q;
  logic [IW-1:0]    last_q;
  logic             proto_err_q;

  logic             full, push, pop, lock_hit;
  logic [NCH-1:0]   arb_gnt, gnt;
  logic [IW-1:0]    gnt_id;
  ent_t             head;

  // full depends on registered state only, so m_data_ok never reaches m_req.
  assign full = (cnt_q == FULL_CNT);

  always_comb begin : arb
    logic found;
    arb_gnt = '0;
    found   = 1'b0;
    if (RR) begin
      // Scan upward from the channel after the last one granted.
      for (int k = 1; k <= NCH; k++) begin
        if (!found && ch_req[(int'(last_q) + k) % NCH]) begin
          arb_gnt[(int'(last_q) + k) % NCH] = 1'b1;
          found = 1'b1;
        end
      end
    end else begin
      // Later iterations overwrite: highest requesting index wins.
      for (int i = 0; i < NCH; i++) begin
        if (ch_req[i]) begin
          arb_gnt    = '0;
          arb_gnt[i] = 1'b1;
        end
      end
    end
  end

  // A stalled request keeps its grant so the downstream payload stays stable.
  assign lock_hit = lock_q & |(lock_gnt_q & ch_req);
  assign gnt      = lock_hit ? lock_gnt_q : arb_gnt;
  assign m_req    = |ch_req & ~full;
  assign push     = m_req & m_addr_ok;
  assign pop      = m_data_ok & (cnt_q != '0);

  always_comb begin
    gnt_id  = '0;
    m_wr    = 1'b0;
    m_size  = '0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        gnt_id = IW'(i);
        if (m_req) begin
          m_wr    = ch_wr[i];
          m_size  = ch_size[2*i +: 2];
          m_addr  = ch_addr[AW*i +: AW];
          m_wdata = ch_wdata[DW*i +: DW];
        end
      end
    end
  end

  assign ch_addr_ok = {NCH{push}} & gnt;
  assign head       = fifo_q[rd_ptr_q];
  assign ch_rdata   = m_rdata;
  assign busy       = (cnt_q != '0);
  assign proto_err  = proto_err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_rsp
    sram_like_arbiter_rsp #(.IW(IW), .CH(g)) u_rsp (
      .pop     (pop),
      .head_id (head.id),
      .head_cx (head.cx),
      .cancel  (ch_cancel[g]),
      .data_ok (ch_data_ok[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      lock_gnt_q  <= '0;
      last_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      // Marking stale slots too is harmless: a push rewrites the whole entry.
      for (int e = 0; e < DEPTH; e++)
        if (ch_cancel[fifo_q[e].id]) fifo_q[e].cx <= 1'b1;

      if (push) begin
        fifo_q[wr_ptr_q] <= '{id: gnt_id, cx: ch_cancel[gnt_id]};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        last_q           <= gnt_id;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase

      if (m_req && !m_addr_ok) begin
        lock_q     <= 1'b1;
        lock_gnt_q <= gnt;
      end else begin
        lock_q     <= 1'b0;
      end

      if (m_data_ok && cnt_q == '0) proto_err_q <= 1'b1;
    end
  end
endmodule
